instruction_encoder: RTL
========================

// Module: instruction_encoder
// PURPOSE
//  Packs field-level instruction requests (opcode, register, stack register, immediate or branch
//  address) into the 16-bit instruction word that the instruction register decodes.
//  Writes each packed word sequentially into program memory through its load port.
//  Sits between the host/loader front end and the program RAM.
//  Word format: [15:10] opcode; [9] reg; [9:8] stack reg; [8:0] immediate; [9:0] branch address.
// PARAMETERS
//  ADDR_W  4   program memory address width
//  DEPTH   16  words available to the encoder; DEPTH <= 2**ADDR_W
// PORTS
//  CLK             in   1       clock, rising edge
//  RESET           in   1       asynchronous, active-low reset
//  START           in   1       synchronous clear: counter, ERR and FSM to IDLE
//  IN_VALID        in   1       request fields valid
//  IN_READY        out  1       encoder accepts a request this cycle
//  FMT             in   2       0=reg+imm9, 1=stack+imm8, 2=branch ba10, 3=no operand
//  OPCODE          in   6       opcode field
//  REG_ADDR        in   1       register select (FMT 0)
//  REG_ADDR_STACK  in   2       stack register select (FMT 1)
//  OPERAND         in   10      imm9 (FMT 0), imm8 (FMT 1) or branch address (FMT 2)
//  MEM_WE          out  1       one-cycle write strobe to program memory
//  MEM_ADDR        out  ADDR_W  write address
//  MEM_DATA        out  16      packed instruction word
//  WORD_COUNT      out  ADDR_W+1 words written since reset/START
//  FULL            out  1       WORD_COUNT == DEPTH
//  ERR             out  1       sticky: an operand did not fit its field
//  BUSY            out  1       FSM not in IDLE
// BEHAVIOUR
//  Reset: FSM=IDLE; MEM_WE=0, MEM_ADDR=0, MEM_DATA=0, WORD_COUNT=0, FULL=0, ERR=0, BUSY=0.
//  IN_READY = (state==IDLE) & !FULL & !START (combinational).
//  FSM IDLE -> PACK on IN_VALID&IN_READY: fields captured into holding registers.
//  PACK (1 cycle): word built from held fields:
//   FMT0 {OPC,REG,OPERAND[8:0]}; FMT1 {OPC,STK,OPERAND[7:0]}; FMT2 {OPC,OPERAND[9:0]};
//   FMT3 {OPC,10'b0}.
//   Range check: FMT0 OPERAND[9]!=0, FMT1 OPERAND[9:8]!=0 or FMT3 OPERAND!=0.
//   A failed check sets ERR, drops the word and returns to IDLE (no write, no count).
//   Otherwise MEM_DATA<=word, MEM_ADDR<=WORD_COUNT[ADDR_W-1:0], -> WRITE.
//  WRITE (1 cycle): MEM_WE=1; WORD_COUNT increments at end of cycle; -> IDLE.
//  MEM_DATA/MEM_ADDR hold their value after WRITE until the next write.
//  Latency: accept edge +2 cycles -> MEM_WE high. Throughput: 1 word per 3 cycles.
//  FULL: asserted the cycle after the DEPTH-th write; no wrap-around; requests blocked.
//  START: priority over all, any state; FSM->IDLE, WORD_COUNT=0, ERR=0, MEM_WE=0.
//   A word in PACK/WRITE is aborted; START during WRITE suppresses that strobe (MEM_WE=0).
//   MEM_ADDR/MEM_DATA are not cleared by START.
//  FMT, OPCODE and OPERAND are sampled only at the accept edge; later changes are ignored.
//  RESET mid-operation: immediate abort, all outputs to reset values, no write strobe.
// TESTING
//  FMT0 OPC=6'h03 REG=1 OPERAND=10'h1A5 -> MEM_WE @ +2, MEM_ADDR=0, MEM_DATA=16'h0FA5, COUNT=1.
//  FMT1 OPC=6'h20 STK=2'b10 OPERAND=10'h03C -> MEM_DATA=16'h823C.
//  FMT2 OPC=6'h11 OPERAND=10'h2AB -> MEM_DATA=16'h46AB.
//  FMT3 OPC=6'h3F -> MEM_DATA=16'hFC00; addresses of back-to-back words increment.
//  FMT0 OPERAND=10'h200 -> ERR=1, no MEM_WE, COUNT unchanged; START -> ERR=0, COUNT=0.
//  DEPTH=4: 4 words -> FULL=1, IN_READY=0, 5th request held (no MEM_WE).
//  RESET in PACK -> no MEM_WE ever; all outputs 0.

Source files
------------

// File: rtl/instruction_encoder.sv
// rtl/instruction_encoder.sv - packs field-level instruction requests into 16-bit words
// and writes them sequentially into program memory.
module instruction_encoder #(
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 16
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              START,
  input  logic              IN_VALID,
  output logic              IN_READY,
  input  logic [1:0]        FMT,
  input  logic [5:0]        OPCODE,
  input  logic              REG_ADDR,
  input  logic [1:0]        REG_ADDR_STACK,
  input  logic [9:0]        OPERAND,
  output logic              MEM_WE,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic [15:0]       MEM_DATA,
  output logic [ADDR_W:0]   WORD_COUNT,
  output logic              FULL,
  output logic              ERR,
  output logic              BUSY
);

  typedef enum logic [1:0] {IDLE, PACK, WRITE} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic                err_q, err_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [15:0]         data_q, data_d;
  logic [1:0]          fmt_q;
  logic [5:0]          opc_q;
  logic                reg_q;
  logic [1:0]          stk_q;
  logic [9:0]          operand_q;
  logic [15:0]         word;
  logic                range_ok;
  logic                full;
  logic                accept;

  assign full     = (count_q == (ADDR_W+1)'(DEPTH));
  assign IN_READY = (state_q == IDLE) && !full && !START;
  assign accept   = IN_VALID && IN_READY;

  // Word assembly and operand range check from the held fields only.
  always_comb begin
    word     = 16'h0000;
    range_ok = 1'b1;
    case (fmt_q)
      2'd0: begin
        word     = {opc_q, reg_q, operand_q[8:0]};
        range_ok = !operand_q[9];
      end
      2'd1: begin
        word     = {opc_q, stk_q, operand_q[7:0]};
        range_ok = (operand_q[9:8] == 2'b00);
      end
      2'd2: word = {opc_q, operand_q};
      default: begin
        word     = {opc_q, 10'b0};
        range_ok = (operand_q == 10'd0);
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    err_d   = err_q;
    addr_d  = addr_q;
    data_d  = data_q;
    if (START) begin
      state_d = IDLE;
      count_d = '0;
      err_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: if (accept) state_d = PACK;
        PACK: begin
          if (!range_ok) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end else begin
            data_d  = word;
            addr_d  = count_q[ADDR_W-1:0];
            state_d = WRITE;
          end
        end
        WRITE: begin
          count_d = count_q + 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q   <= IDLE;
      count_q   <= '0;
      err_q     <= 1'b0;
      addr_q    <= '0;
      data_q    <= 16'h0000;
      fmt_q     <= 2'd0;
      opc_q     <= 6'd0;
      reg_q     <= 1'b0;
      stk_q     <= 2'd0;
      operand_q <= 10'd0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      if (accept) begin
        fmt_q     <= FMT;
        opc_q     <= OPCODE;
        reg_q     <= REG_ADDR;
        stk_q     <= REG_ADDR_STACK;
        operand_q <= OPERAND;
      end
    end
  end

  // Strobe is gated by START so an abort in WRITE never reaches memory.
  assign MEM_WE     = (state_q == WRITE) && !START;
  assign MEM_ADDR   = addr_q;
  assign MEM_DATA   = data_q;
  assign WORD_COUNT = count_q;
  assign FULL       = full;
  assign ERR        = err_q;
  assign BUSY       = (state_q != IDLE);

endmodule
